// File: rtl/rx_status_sync.sv
// Multi-channel level synchroniser into tx_frame_clk: per-channel sync chain, stability
// filter and optional sticky latch, with registered rise/fall pulses and an aggregate change flag.
module rx_status_sync #(
    parameter int                N_CH        = 5,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CYCLES = 4,
    parameter logic [N_CH-1:0]   STICKY_MASK = 5'b10000
) (
    input  logic            tx_frame_clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    input  logic [N_CH-1:0] sticky_clr,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            change_any
);

    localparam int CW = $clog2(FILT_CYCLES) + 1;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("rx_status_sync: SYNC_STAGES must be >= 2");
        end
        if (FILT_CYCLES < 1) begin : g_bad_filt_cycles
            $error("rx_status_sync: FILT_CYCLES must be >= 1");
        end
    endgenerate

    // Pure flop-to-flop chain; index 0 is the metastability-exposed stage.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][N_CH-1:0] sync_ff;
    logic [N_CH-1:0]          s;

    logic [N_CH-1:0][CW-1:0]  cnt;
    logic [N_CH-1:0][CW-1:0]  cnt_next;
    logic [N_CH-1:0]          q;
    logic [N_CH-1:0]          q_next;
    logic [N_CH-1:0]          dout_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tx_frame_clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_ff[SYNC_STAGES-1];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        q_next    = q;
        dout_next = dout;
        cnt_next  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] != q[i]) begin
                if (cnt[i] == CW'(FILT_CYCLES - 1)) begin
                    q_next[i] = s[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end

            // Sticky channels: a high level always wins over a simultaneous clear.
            if (STICKY_MASK[i]) begin
                if (q_next[i]) begin
                    dout_next[i] = 1'b1;
                end else if (sticky_clr[i]) begin
                    dout_next[i] = 1'b0;
                end
            end else begin
                dout_next[i] = q_next[i];
            end
        end
    end

    always_ff @(posedge tx_frame_clk) begin
        if (rst) begin
            cnt        <= '0;
            q          <= '0;
            dout       <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            change_any <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            q          <= q_next;
            dout       <= dout_next;
            rise_pulse <= dout_next & ~dout;
            fall_pulse <= ~dout_next & dout;
            change_any <= |(dout_next ^ dout);
        end
    end

endmodule

// File: tb/tb_rx_status_sync.sv
// Directed bench for rx_status_sync: default 5-channel instance plus an 8-channel,
// 3-stage, single-cycle-filter instance for the reparametrised latency case.
module tb_rx_status_sync;

    logic       clk;
    logic       rst;
    logic [4:0] din;
    logic [4:0] sticky_clr;
    logic [4:0] dout;
    logic [4:0] rise_pulse;
    logic [4:0] fall_pulse;
    logic       change_any;

    logic [7:0] din_b;
    logic [7:0] clr_b;
    logic [7:0] dout_b;
    logic [7:0] rise_b;
    logic [7:0] fall_b;
    logic       change_any_b;

    int n_cmp = 0;
    int n_err = 0;
    int rise_cnt [5];
    int fall_cnt [5];
    int chg_cnt;
    int both_cnt;

    rx_status_sync dut (
        .tx_frame_clk (clk),
        .rst          (rst),
        .din          (din),
        .sticky_clr   (sticky_clr),
        .dout         (dout),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .change_any   (change_any)
    );

    rx_status_sync #(
        .N_CH        (8),
        .SYNC_STAGES (3),
        .FILT_CYCLES (1),
        .STICKY_MASK (8'h00)
    ) dut_b (
        .tx_frame_clk (clk),
        .rst          (rst),
        .din          (din_b),
        .sticky_clr   (clr_b),
        .dout         (dout_b),
        .rise_pulse   (rise_b),
        .fall_pulse   (fall_b),
        .change_any   (change_any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, settle, and accumulate pulse statistics for the default instance.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 5; ch++) begin
            rise_cnt[ch] += int'(rise_pulse[ch]);
            fall_cnt[ch] += int'(fall_pulse[ch]);
        end
        chg_cnt += int'(change_any);
        if (|(rise_pulse & fall_pulse)) both_cnt++;
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < 5; ch++) begin
            rise_cnt[ch] = 0;
            fall_cnt[ch] = 0;
        end
        chg_cnt = 0;
    endtask

    initial begin
        rst        = 1'b1;
        din        = 5'h1F;
        sticky_clr = 5'h00;
        din_b      = 8'h00;
        clr_b      = 8'h00;
        both_cnt   = 0;
        clear_counts();

        // 1: reset holds everything low, then full latency on release
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_dout", 32'(dout), 32'h0);
            check("rst_rise", 32'(rise_pulse), 32'h0);
            check("rst_chg", 32'(change_any), 32'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t1_latency_dout", 32'(dout), 32'h0);
        end
        tick();
        check("t1_dout_up", 32'(dout), 32'h1F);
        check("t1_rise", 32'(rise_pulse), 32'h1F);
        check("t1_chg", 32'(change_any), 32'h1);
        tick();
        check("t1_rise_one_cycle", 32'(rise_pulse), 32'h0);
        check("t1_chg_one_cycle", 32'(change_any), 32'h0);
        check("t1_dout_hold", 32'(dout), 32'h1F);
        check("t1_b_idle", 32'(dout_b), 32'h0);

        din = 5'h00;
        repeat (5) tick();
        check("t1_fall_latency", 32'(dout), 32'h1F);
        tick();
        check("t1_dout_down", 32'(dout), 32'h10);
        check("t1_fall", 32'(fall_pulse), 32'h0F);
        tick();
        sticky_clr = 5'h10;
        tick();
        sticky_clr = 5'h00;
        check("t1_clr_dout", 32'(dout), 32'h0);
        check("t1_clr_fall", 32'(fall_pulse), 32'h10);
        tick();
        check("t1_clr_fall_one_cycle", 32'(fall_pulse), 32'h0);

        // 2: 3-cycle glitch is filtered out
        clear_counts();
        din[0] = 1'b1;
        repeat (3) tick();
        din[0] = 1'b0;
        repeat (10) tick();
        check("t2_dout", 32'(dout), 32'h0);
        check("t2_rise_cnt", 32'(rise_cnt[0]), 32'h0);
        check("t2_chg_cnt", 32'(chg_cnt), 32'h0);

        // 3: 10-cycle level on channel 1 passes through both edges
        clear_counts();
        din[1] = 1'b1;
        repeat (5) tick();
        check("t3_pre_rise", 32'(dout), 32'h0);
        tick();
        check("t3_dout_up", 32'(dout), 32'h02);
        check("t3_rise", 32'(rise_pulse), 32'h02);
        repeat (4) tick();
        din[1] = 1'b0;
        repeat (5) tick();
        check("t3_pre_fall", 32'(dout), 32'h02);
        tick();
        check("t3_dout_down", 32'(dout), 32'h0);
        check("t3_fall", 32'(fall_pulse), 32'h02);
        repeat (3) tick();
        check("t3_rise_cnt", 32'(rise_cnt[1]), 32'h1);
        check("t3_fall_cnt", 32'(fall_cnt[1]), 32'h1);

        // 4: sticky channel 4 holds until cleared; clear ignored while level high
        clear_counts();
        din[4] = 1'b1;
        repeat (6) tick();
        check("t4_dout_up", 32'(dout), 32'h10);
        check("t4_rise", 32'(rise_pulse), 32'h10);
        repeat (2) tick();
        din[4] = 1'b0;
        repeat (10) tick();
        check("t4_sticky_hold", 32'(dout), 32'h10);
        sticky_clr[4] = 1'b1;
        tick();
        sticky_clr = 5'h00;
        check("t4_clr_dout", 32'(dout), 32'h0);
        check("t4_clr_fall", 32'(fall_pulse), 32'h10);
        tick();
        din[4] = 1'b1;
        repeat (8) tick();
        check("t4_dout_up2", 32'(dout), 32'h10);
        sticky_clr[4] = 1'b1;
        tick();
        sticky_clr = 5'h00;
        check("t4_set_wins_dout", 32'(dout), 32'h10);
        check("t4_set_wins_fall", 32'(fall_pulse), 32'h0);
        tick();
        check("t4_fall_cnt", 32'(fall_cnt[4]), 32'h1);
        check("t4_rise_cnt", 32'(rise_cnt[4]), 32'h2);
        din[4] = 1'b0;
        repeat (8) tick();
        sticky_clr[4] = 1'b1;
        tick();
        sticky_clr = 5'h00;
        tick();
        check("t4_cleanup", 32'(dout), 32'h0);

        // 5: reset mid-filter discards progress; full latency after release
        clear_counts();
        din[2] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_dout", 32'(dout), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t5_latency_dout", 32'(dout), 32'h0);
        end
        tick();
        check("t5_dout_up", 32'(dout), 32'h04);
        check("t5_rise", 32'(rise_pulse), 32'h04);
        tick();
        check("t5_rise_cnt", 32'(rise_cnt[2]), 32'h1);

        // 6: 3-stage sync, 1-cycle filter, 8 channels -> latency 4
        din_b[3] = 1'b1;
        repeat (3) tick();
        check("t6_pre_rise", 32'(dout_b), 32'h0);
        tick();
        check("t6_dout_up", 32'(dout_b), 32'h08);
        check("t6_rise", 32'(rise_b), 32'h08);
        tick();
        din_b[5] = 1'b1;
        tick();
        din_b[5] = 1'b0;
        repeat (2) tick();
        check("t6_pulse_pre", 32'(dout_b), 32'h08);
        tick();
        check("t6_pulse_dout", 32'(dout_b), 32'h28);
        check("t6_pulse_rise", 32'(rise_b), 32'h20);
        tick();
        check("t6_pulse_end", 32'(dout_b), 32'h08);
        check("t6_pulse_fall", 32'(fall_b), 32'h20);
        check("t6_pulse_chg", 32'(change_any_b), 32'h1);

        check("never_both_pulses", 32'(both_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
